// File: rtl/sched_pkg.sv
// Shared state encoding, default sizing and width helper
// for the SDRAM access scheduler.
package sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_REQ   = 2'd2,
    S_RD_BURST = 2'd3
  } state_t;

  localparam int unsigned BURST_LEN    = 8;
  localparam int unsigned PIX_W        = 16;
  localparam int unsigned FIFO_DEPTH   = 16;
  localparam int unsigned LEVEL_W      = 10;
  localparam int unsigned RD_LOW_WATER = 32;
  localparam int unsigned STARVE_LIMIT = 4;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdram_access_scheduler_if.sv
// Writer, reader and facade signals of the scheduler.
// slave = scheduler side, master = environment side.
interface sdram_access_scheduler_if
  import sched_pkg::*;
#(
  parameter int PW = PIX_W,
  parameter int LW = LEVEL_W,
  parameter int CW = cnt_w(FIFO_DEPTH)
) ();

  logic          i_wr_valid;
  logic [PW-1:0] i_wr_pixel;
  logic          o_wr_ready;
  logic          i_rd_enable;
  logic [LW-1:0] i_rd_level;
  logic [PW-1:0] o_rd_pixel;
  logic          o_rd_valid;
  logic          o_fac_write_req;
  logic [PW-1:0] o_fac_pixel;
  logic          o_fac_read_req;
  logic          i_fac_busy_wr;
  logic          i_fac_busy_rd;
  logic          i_fac_ready;
  logic [PW-1:0] i_fac_pixel;
  logic [1:0]    o_state;
  logic [CW-1:0] o_wr_count;

  modport slave (
    input  i_wr_valid, i_wr_pixel,
    input  i_rd_enable, i_rd_level,
    input  i_fac_busy_wr, i_fac_busy_rd,
    input  i_fac_ready, i_fac_pixel,
    output o_wr_ready, o_rd_pixel, o_rd_valid,
    output o_fac_write_req, o_fac_pixel,
    output o_fac_read_req, o_state, o_wr_count
  );

  modport master (
    output i_wr_valid, i_wr_pixel,
    output i_rd_enable, i_rd_level,
    output i_fac_busy_wr, i_fac_busy_rd,
    output i_fac_ready, i_fac_pixel,
    input  o_wr_ready, o_rd_pixel, o_rd_valid,
    input  o_fac_write_req, o_fac_pixel,
    input  o_fac_read_req, o_state, o_wr_count
  );

endinterface

// File: rtl/sched_fifo.sv
// Synchronous FIFO with occupancy count; push is refused
// when full even if a pop happens in the same cycle.
module sched_fifo #(
  parameter int Width      = 16,
  parameter int Depth      = 16,
  parameter int CountWidth = $clog2(Depth) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_push,
  input  logic [Width-1:0]      i_data,
  input  logic                  i_pop,
  output logic [Width-1:0]      o_data,
  output logic [CountWidth-1:0] o_count,
  output logic                  o_full
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0]      r_mem [Depth];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CountWidth-1:0] r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == CountWidth'(Depth));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers are AW bits wide, so they wrap modulo Depth.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/sdram_access_scheduler.sv
// Arbitrates the SDRAM facade between pixel ingest (writes)
// and VGA line-buffer refill (reads) with writer anti-starvation.
module sdram_access_scheduler
  import sched_pkg::*;
#(
  parameter int BurstLength     = BURST_LEN,
  parameter int PixelBitWidth   = PIX_W,
  parameter int FifoDepth       = FIFO_DEPTH,
  parameter int LevelWidth      = LEVEL_W,
  parameter int ReadLowWater    = RD_LOW_WATER,
  parameter int StarvationLimit = STARVE_LIMIT
) (
  input  logic                      CLK,
  input  logic                      RST,
  sdram_access_scheduler_if.slave   bus
);

  localparam int CW = cnt_w(FifoDepth);
  localparam int BW = $clog2(BurstLength);
  localparam int SW = $clog2(StarvationLimit + 1);

  localparam logic [BW-1:0]         LAST_BEAT  = BW'(BurstLength - 1);
  localparam logic [SW-1:0]         STARVE_MAX = SW'(StarvationLimit);
  localparam logic [LevelWidth-1:0] LOW_WATER  = LevelWidth'(ReadLowWater);

  state_t                   r_state;
  logic [BW-1:0]            r_beat;
  logic [SW-1:0]            r_starve;
  logic                     r_rd_valid;
  logic [PixelBitWidth-1:0] r_rd_pixel;

  logic [CW-1:0]            w_count;
  logic                     w_full;
  logic [PixelBitWidth-1:0] w_head;
  logic                     w_push;
  logic                     w_wr_req;
  logic                     w_rd_req;
  logic                     w_rd_urgent;
  logic                     w_wr_elig;
  logic                     w_starved;

  assign w_push      = bus.i_wr_valid && !w_full;
  assign w_wr_req    = (r_state == S_WR_BURST) && !bus.i_fac_busy_wr;
  assign w_rd_req    = (r_state == S_RD_REQ) && !bus.i_fac_busy_rd;
  assign w_rd_urgent = bus.i_rd_enable && (bus.i_rd_level < LOW_WATER);
  assign w_wr_elig   = (w_count >= CW'(BurstLength));
  assign w_starved   = (r_starve == STARVE_MAX);

  sched_fifo #(
    .Width      (PixelBitWidth),
    .Depth      (FifoDepth),
    .CountWidth (CW)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push),
    .i_data  (bus.i_wr_pixel),
    .i_pop   (w_wr_req),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_starve   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_pixel <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (w_wr_elig && w_starved) begin
            r_state  <= S_WR_BURST;
            r_starve <= '0;
          end else if (w_rd_urgent) begin
            r_state <= S_RD_REQ;
            // Only reads that bypass a full writer count as starvation.
            if (w_full && !w_starved)
              r_starve <= r_starve + 1'b1;
          end else if (w_wr_elig) begin
            r_state  <= S_WR_BURST;
            r_starve <= '0;
          end
        end
        S_WR_BURST: begin
          if (w_wr_req) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) r_state <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (!bus.i_fac_busy_rd) r_state <= S_RD_BURST;
        end
        S_RD_BURST: begin
          if (bus.i_fac_ready) begin
            r_rd_pixel <= bus.i_fac_pixel;
            r_rd_valid <= 1'b1;
            r_beat     <= r_beat + 1'b1;
            if (r_beat == LAST_BEAT) r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.o_wr_ready      = !w_full;
  assign bus.o_wr_count      = w_count;
  assign bus.o_fac_write_req = w_wr_req;
  assign bus.o_fac_pixel     = w_wr_req ? w_head : '0;
  assign bus.o_fac_read_req  = w_rd_req;
  assign bus.o_rd_pixel      = r_rd_pixel;
  assign bus.o_rd_valid      = r_rd_valid;
  assign bus.o_state         = r_state;

endmodule

// File: doc/sdram_access_scheduler.md
# sdram_access_scheduler

Arbitrates the single SDRAM facade between the UART pixel-ingest path (writer) and the VGA line-buffer refill path (reader). Writer pixels are staged in a small FIFO and sent as full bursts. Reader bursts are issued when the VGA line buffer drains below a watermark. A starvation counter guarantees writer progress during long display periods.

## Interface
- BurstLength, 8, pixels per SDRAM burst (power of two, ≥2)
- PixelBitWidth, 16, pixel width
- FifoDepth, 16, writer staging FIFO depth (power of two, ≥ 2·BurstLength)
- LevelWidth, 10, width of the reader line-buffer level input
- ReadLowWater, 32, reader becomes urgent when level < this
- StarvationLimit, 4, consecutive read grants allowed while the writer FIFO is full
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-low
- i_wr_valid  in  1  writer offers pixel
- i_wr_pixel  in  PixelBitWidth  writer pixel
- o_wr_ready  out  1  FIFO not full; a pixel transfers when valid && ready
- i_rd_enable  in  1  display active; the reader is ignored when low
- i_rd_level  in  LevelWidth  VGA line-buffer occupancy
- o_rd_pixel  out  PixelBitWidth  pixel returned to the line buffer
- o_rd_valid  out  1  o_rd_pixel valid for one cycle
- o_fac_write_req  out  1  write beat to facade
- o_fac_pixel  out  PixelBitWidth  pixel for the write beat
- o_fac_read_req  out  1  one-cycle read-burst request
- i_fac_busy_wr  in  1  facade cannot accept a write beat
- i_fac_busy_rd  in  1  facade cannot accept a read request
- i_fac_ready  in  1  facade read pixel valid
- i_fac_pixel  in  PixelBitWidth  facade read pixel
- o_state  out  2  current FSM state (debug)
- o_wr_count  out  clog2(FifoDepth)+1  FIFO occupancy

## Operation
- **States:** IDLE=0, WR_BURST=1, RD_REQ=2, RD_BURST=3.
- **Eligibility:**
  - rd_urgent = i_rd_enable && i_rd_level < ReadLowWater.
  - wr_elig = o_wr_count ≥ BurstLength.
- **IDLE grant (priority order):**
  1. wr_elig && starve_cnt == StarvationLimit → WR_BURST.
  2. rd_urgent → RD_REQ.
  3. wr_elig → WR_BURST.
  4. Otherwise stay in IDLE.
- **starve_cnt:**
  - Increments on each RD_REQ grant made while the FIFO is full, saturating at StarvationLimit.
  - Clears on every WR_BURST grant.
- **WR_BURST:**
  - o_fac_write_req = !i_fac_busy_wr; o_fac_pixel = FIFO head.
  - Each cycle with write_req high pops the FIFO and increments beat_cnt.
  - After BurstLength beats → IDLE.
  - Busy stalls the burst without losing a beat.
- **RD_REQ:** o_fac_read_req pulses for one cycle on the first cycle with !i_fac_busy_rd, then → RD_BURST.
- **RD_BURST:**
  - Each i_fac_ready registers i_fac_pixel to o_rd_pixel, raises o_rd_valid the next cycle, and increments beat_cnt.
  - After BurstLength returns → IDLE.
  - i_fac_ready outside RD_BURST is ignored.
- **FIFO:**
  - Push on i_wr_valid && o_wr_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FifoDepth.
  - Push is accepted in any state.
- **Display stop:** i_rd_enable falling during RD_BURST does not abort the burst; remaining returns are still forwarded.

## Timing
- **Reset values:**
  - Outputs: o_wr_ready=1; all other outputs 0; o_state=IDLE.
  - Internal: FIFO empty, starve_cnt=0, beat_cnt=0.
- **Reset mid-burst:** reset returns to IDLE on the same edge and discards partial burst and FIFO contents.
- **Decision latency:** one cycle in IDLE, then FSM transition.
- **Write burst:** first write beat is the cycle after entering WR_BURST. Minimum burst is BurstLength cycles with no busy; IDLE is re-entered the cycle after the last beat.
- **Read return:** o_rd_valid lags i_fac_ready by exactly 1 cycle.
- **o_wr_ready** derives from the registered count. It is low when count == FifoDepth, even if a pop occurs in the same cycle.
- **Back-to-back grants:** at least one IDLE cycle between any two bursts.

## Structure
- Package sched_pkg:
  - State encoding localparams.
  - Count width function.
- Sub-module sched_fifo (synchronous FIFO with count output, parameterised by width and depth). The scheduler FSM and counters stay in the top module.

## Test plan
- **Writer burst:** reset, push 8 pixels 0x0001..0x0008, i_rd_enable=0 → o_fac_write_req high 8 consecutive cycles carrying 0x0001..0x0008 in order, then o_state=IDLE, o_wr_count=0.
- **Write stall:** same stimulus with i_fac_busy_wr high on beats 3–5 → exactly 8 beats, no duplicate or missing pixel, burst ends 3 cycles later.
- **Read priority:** FIFO count=8, i_rd_enable=1, i_rd_level=10 → o_fac_read_req pulses once; 8 returned pixels appear on o_rd_pixel, each 1 cycle after i_fac_ready.
- **Starvation:** FIFO full (16), level held at 0 → 4 read bursts granted, then the 5th grant is WR_BURST, then reads resume.
- **FIFO boundary:** push 16 pixels with no pop → o_wr_ready=0 after the 16th; a 17th i_wr_valid is not accepted. Simultaneous push and pop at count 9 → count stays 9.
- **Reset mid-burst:** reset asserted on beat 4 of WR_BURST → next cycle o_state=0, o_fac_write_req=0, o_wr_count=0, o_wr_ready=1.
